// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage core: forwarding selects, load-use bubbles, branch flushes and memory freeze.
// All responses are combinational in the same cycle; mem_stall holds every stage and the shadow scoreboard.
module hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic              rs1_used_d,
   input  logic              rs2_used_d,
   input  logic [REG_AW-1:0] rd_d,
   input  logic              reg_write_d,
   input  logic              load_d,
   input  logic              pc_src_e,
   input  logic              mem_stall,
   output logic [1:0]        fwd_rs1,
   output logic [1:0]        fwd_rs2,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              stall_m,
   output logic              stall_w,
   output logic              flush_d,
   output logic              flush_e,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef struct packed {
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              rs1_used;
      logic              rs2_used;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              load;
   } e_stage_t;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              reg_write;
   } wb_stage_t;

   typedef enum logic {RUN = 1'b0, FREEZE = 1'b1} state_t;

   state_t    state, state_nxt;
   e_stage_t  e_q;
   wb_stage_t m_q, w_q;
   logic      freeze;
   logic      lu;
   logic      stall_fd;

   function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] rs,
                                          input wb_stage_t m, input wb_stage_t w);
      logic [1:0] sel;
      sel = 2'b00;
      if (used && m.reg_write && (m.rd != '0) && (m.rd == rs))
         sel = 2'b10;
      else if (used && w.reg_write && (w.rd != '0) && (w.rd == rs))
         sel = 2'b01;
      return sel;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (mem_stall)  state_nxt = FREEZE;
         FREEZE:  if (!mem_stall) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Freeze must bite in the first cycle mem_stall rises, so it is not just the registered state.
   always_comb begin
      freeze = 1'b0;
      case (state)
         RUN:     freeze = mem_stall;
         FREEZE:  freeze = mem_stall;
         default: freeze = 1'b0;
      endcase
   end

   assign lu = e_q.load && (e_q.rd != '0) &&
               ((rs1_used_d && (rs1_d == e_q.rd)) || (rs2_used_d && (rs2_d == e_q.rd)));

   always_comb begin
      stall_fd = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      if (!freeze) begin
         stall_fd = lu && !pc_src_e;
         flush_d  = pc_src_e;
         flush_e  = pc_src_e || lu;
      end
   end

   assign stall_f = freeze || stall_fd;
   assign stall_d = freeze || stall_fd;
   assign stall_e = freeze;
   assign stall_m = freeze;
   assign stall_w = freeze;

   assign fwd_rs1 = fwd_sel(e_q.rs1_used, e_q.rs1, m_q, w_q);
   assign fwd_rs2 = fwd_sel(e_q.rs2_used, e_q.rs2, m_q, w_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else if (!freeze) begin
         if (flush_e)
            e_q <= '0;
         else
            e_q <= '{rs1: rs1_d, rs2: rs2_d, rs1_used: rs1_used_d, rs2_used: rs2_used_d,
                     rd: rd_d, reg_write: reg_write_d, load: load_d};
         m_q <= '{rd: e_q.rd, reg_write: e_q.reg_write};
         w_q <= m_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_fd && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (!freeze && pc_src_e && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expectations queue up per cycle and a negedge monitor compares them.
module tb_hazard_ctrl;

   localparam int AW = 5;
   localparam int CW = 4;
   localparam int VW = 2 + 2 + 5 + 2 + CW + CW;

   typedef logic [VW-1:0] vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
   logic          rs1_used_d = 1'b0, rs2_used_d = 1'b0, reg_write_d = 1'b0, load_d = 1'b0;
   logic          pc_src_e = 1'b0, mem_stall = 1'b0;
   logic [1:0]    fwd_rs1, fwd_rs2;
   logic          stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e;
   logic [CW-1:0] stall_cnt, flush_cnt;

   vec_t  exp_q[$];
   string name_q[$];
   int    tests = 0;
   int    fails = 0;
   vec_t  act;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
      .rd_d(rd_d), .reg_write_d(reg_write_d), .load_d(load_d),
      .pc_src_e(pc_src_e), .mem_stall(mem_stall),
      .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
      .flush_d(flush_d), .flush_e(flush_e),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   assign act = {fwd_rs1, fwd_rs2, stall_f, stall_d, stall_e, stall_m, stall_w,
                 flush_d, flush_e, stall_cnt, flush_cnt};

   function automatic vec_t mk(input logic [1:0] f1, input logic [1:0] f2, input logic [4:0] st,
                               input logic fd, input logic fe,
                               input logic [CW-1:0] sc, input logic [CW-1:0] fc);
      return {f1, f2, st, fd, fe, sc, fc};
   endfunction

   task automatic expect_out(input string nm, input vec_t v);
      exp_q.push_back(v);
      name_q.push_back(nm);
   endtask

   task automatic set_in(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic u1,
                         input logic u2, input logic [AW-1:0] rd, input logic rw, input logic ld,
                         input logic pc, input logic ms);
      rs1_d = r1; rs2_d = r2; rs1_used_d = u1; rs2_used_d = u2;
      rd_d = rd; reg_write_d = rw; load_d = ld; pc_src_e = pc; mem_stall = ms;
   endtask

   task automatic drive(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic u1,
                        input logic u2, input logic [AW-1:0] rd, input logic rw, input logic ld,
                        input logic pc, input logic ms);
      @(posedge clk);
      #1;
      set_in(r1, r2, u1, u2, rd, rw, ld, pc, ms);
   endtask

   task automatic do_reset(input string nm);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      set_in('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(nm, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: combinational outputs are settled by the falling edge.
   always @(negedge clk) begin
      vec_t  e;
      string n;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         tests++;
         if (act !== e) begin
            fails++;
            $display("FAIL %s: got fwd=%b/%b st=%b fl=%b%b sc=%0d fc=%0d, want fwd=%b/%b st=%b fl=%b%b sc=%0d fc=%0d",
                     n, act[VW-1 -: 2], act[VW-3 -: 2], act[VW-5 -: 5], act[2*CW+1], act[2*CW],
                     act[2*CW-1 -: CW], act[CW-1:0],
                     e[VW-1 -: 2], e[VW-3 -: 2], e[VW-5 -: 5], e[2*CW+1], e[2*CW],
                     e[2*CW-1 -: CW], e[CW-1:0]);
         end
      end
   end

   initial begin
      int sat;

      // Back-to-back ALU forwarding: M path, then W path.
      do_reset("reset_state");
      drive(0, 0, 0, 0, 5, 1, 0, 0, 0); expect_out("alu_add", '0);
      drive(5, 1, 1, 1, 6, 1, 0, 0, 0); expect_out("alu_sub_in_d", '0);
      drive(5, 0, 1, 0, 7, 1, 0, 0, 0); expect_out("alu_fwd_m", mk(2'b10, 2'b00, 5'b0, 0, 0, 0, 0));
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("alu_fwd_w", mk(2'b01, 2'b00, 5'b0, 0, 0, 0, 0));

      // x0 is never forwarded.
      do_reset("reset_x0");
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0); expect_out("x0_write", '0);
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0); expect_out("x0_read_d", '0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("x0_m", '0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("x0_w", '0);

      // Load-use: one bubble, then W-path forwarding of the load result.
      do_reset("reset_lu");
      drive(0, 0, 0, 0, 7, 1, 1, 0, 0); expect_out("lu_load", '0);
      drive(7, 0, 1, 0, 8, 1, 0, 0, 0); expect_out("lu_bubble", mk(2'b00, 2'b00, 5'b11000, 0, 1, 0, 0));
      drive(7, 0, 1, 0, 8, 1, 0, 0, 0); expect_out("lu_release", mk(2'b00, 2'b00, 5'b0, 0, 0, 1, 0));
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("lu_fwd_w", mk(2'b01, 2'b00, 5'b0, 0, 0, 1, 0));

      // Branch overrides load-use.
      do_reset("reset_br");
      drive(0, 0, 0, 0, 7, 1, 1, 0, 0); expect_out("br_load", '0);
      drive(7, 0, 1, 0, 8, 1, 0, 1, 0); expect_out("br_wins", mk(2'b00, 2'b00, 5'b0, 1, 1, 0, 0));
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("br_counts", mk(2'b00, 2'b00, 5'b0, 0, 0, 0, 1));

      // Freeze with a held branch: shadow (and so fwd) holds, flush only on release.
      do_reset("reset_frz");
      drive(0, 0, 0, 0, 5, 1, 0, 0, 0); expect_out("frz_add", '0);
      drive(5, 0, 1, 0, 0, 0, 0, 0, 0); expect_out("frz_sub", '0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
         expect_out($sformatf("frz_hold%0d", i), mk(2'b10, 2'b00, 5'b11111, 0, 0, 0, 0));
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_out("frz_release", mk(2'b10, 2'b00, 5'b0, 1, 1, 0, 0));
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("frz_after", mk(2'b00, 2'b00, 5'b0, 0, 0, 0, 1));

      // Self-dependent loads give a load-use every other cycle; stall_cnt saturates at 15.
      do_reset("reset_sat");
      for (int t = 0; t < 43; t++) begin
         logic [31:0] tv;
         tv  = t;
         sat = (t / 2 > 15) ? 15 : t / 2;
         drive(7, 0, 1, 0, 7, 1, 1, 0, 0);
         expect_out($sformatf("sat_t%0d", t),
                    mk((tv[0] && t >= 3) ? 2'b01 : 2'b00, 2'b00, tv[0] ? 5'b11000 : 5'b0,
                       1'b0, tv[0], CW'(sat), '0));
      end

      // Asynchronous reset in the middle of a load-use stall.
      @(posedge clk);
      #1;
      set_in(7, 0, 1, 0, 7, 1, 1, 0, 0);
      #2;
      rst_n = 1'b0;
      expect_out("arst_mid_stall", '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_in('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("arst_empty_pipe", '0);

      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core. Drives the execute-stage forwarding selects (fwd_rs1/fwd_rs2), the per-stage stall and flush enables, and handles load-use bubbles, taken-branch/jump flushes and data-memory freezes.
- Keeps its own shadow copy of the E/M/W destination-register scoreboard, advanced with exactly the stall/flush it issues. Sits beside the pipeline registers and needs no pipeline-register taps.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- rs1_d  in  REG_AW  rs1 address of the instruction in decode.
- rs2_d  in  REG_AW  rs2 address of the instruction in decode.
- rs1_used_d  in  1  decode instruction reads rs1.
- rs2_used_d  in  1  decode instruction reads rs2.
- rd_d  in  REG_AW  destination address of the instruction in decode.
- reg_write_d  in  1  decode instruction writes rd.
- load_d  in  1  decode instruction is a load.
- pc_src_e  in  1  taken branch or jump resolved in execute.
- mem_stall  in  1  data memory not ready; freeze whole pipe.
- fwd_rs1  out  2  00 rd1_e, 01 result_w, 10 alu_result_m; 11 never driven.
- fwd_rs2  out  2  same encoding as fwd_rs1.
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1 each  hold the corresponding stage register.
- flush_d, flush_e  out  1 each  load a bubble into the D or E register.
- stall_cnt  out  CNT_W  count of load-use bubble cycles.
- flush_cnt  out  CNT_W  count of branch flush events.

Behaviour:
- Shadow regs:
  - E stage: rs1_e, rs2_e, rs1_used_e, rs2_used_e, rd_e, reg_write_e, load_e.
  - M stage: rd_m, reg_write_m, load_m.
  - W stage: rd_w, reg_write_w.
  - Bubble value is all fields 0.
- Reset (async, rst_n low): all shadow regs become bubbles; counters = 0; FSM = RUN. With idle inputs every output is 0 and fwd_* = 00 in the same cycle.
- Forwarding (combinational from shadow E/M/W), per operand x:
  - 10 if used_e and reg_write_m and rd_m != 0 and rd_m == rsx_e.
  - Otherwise 01 if used_e and reg_write_w and rd_w != 0 and rd_w == rsx_e.
  - Otherwise 00.
  - M has priority over W. x0 is never forwarded.
- Load-use (lu) = load_e and rd_e != 0 and ((rs1_used_d and rs1_d == rd_e) or (rs2_used_d and rs2_d == rd_e)). Response: stall_f = stall_d = 1 and flush_e = 1, for exactly one cycle per occurrence.
- Branch: pc_src_e = 1 gives flush_d = flush_e = 1. If lu and pc_src_e are both high, the branch wins: flush only, no stall_f/stall_d, no stall_cnt increment.
- FSM states:
  - RUN: mem_stall = 1 goes to FREEZE.
  - FREEZE: all five stall_* = 1; flush_d, flush_e, fwd-unrelated hazard responses forced 0; shadow regs hold; counters hold. Stays while mem_stall = 1.
  - FREEZE exits to RUN in the cycle mem_stall = 0. Hazards are then evaluated normally that cycle, so a pc_src_e held through the freeze flushes on the release cycle.
- FSM outputs are combinational from state and mem_stall: the freeze takes effect in the first cycle mem_stall is high.
- Shadow update on clk rising edge when not frozen:
  - E <= bubble if flush_e, else the D-stage fields.
  - M <= E; W <= M.
- Under lu, the D fields are not captured, because E receives a bubble.
- Counters:
  - stall_cnt increments once per lu cycle not overridden by a branch.
  - flush_cnt increments once per pc_src_e cycle outside FREEZE.
  - Both saturate at all-ones; neither wraps.
- Reset mid-freeze or mid-stall: immediate return to RUN with empty shadow pipe.

Test Plan:
- Back-to-back ALU, add x5 then sub x6,x5,x1 → next cycle fwd_rs1 = 10, fwd_rs2 = 00; one cycle later, a third instruction reading x5 gets fwd = 01.
- Write to x0 then read x0 → fwd_rs1 = 00 at every stage.
- Load x7 followed by a reader of x7 → exactly 1 cycle of stall_f = stall_d = flush_e = 1, stall_cnt = 1; following cycle fwd_rs1 = 01 (load result from W path after the bubble).
- pc_src_e pulse with lu also true → flush_d = flush_e = 1, stalls 0, flush_cnt = 1, stall_cnt = 0.
- mem_stall high 3 cycles while pc_src_e held → 3 cycles all stall_* = 1, flush = 0, shadow unchanged; release cycle flush_d = flush_e = 1, flush_cnt increments once.
- CNT_W = 4, 20 lu events → stall_cnt = 15 and held there; rst_n low asynchronously mid-stall → all outputs 0 before the next edge.
